// File: rtl/sram_like_arbiter.sv
// Two-requester arbiter for one sram-like port: grants one address phase per cycle and
// routes in-order responses back to their owner through a small tag FIFO.
module sram_like_arbiter #(
  parameter int MAX_OUTS     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  outs_cnt,
  output logic        err_spurious
);

  // Handshake: a request is transferred on a cycle where mem_req=1 and mem_addr_ok=1;
  // once mem_req is raised the granted requester is locked until that transfer happens.

  logic [2:0] cnt, wptr, rptr;
  logic [7:0] tags;
  logic       lock_valid, lock_id;
  logic [3:0] starve_cnt;
  logic       full, empty, grant, win, accept, pop, head;

  function automatic logic [2:0] ptr_inc(input logic [2:0] p);
    return (p == MAX_OUTS[2:0] - 3'd1) ? 3'd0 : p + 3'd1;
  endfunction

  always_comb begin
    full  = (cnt == MAX_OUTS[2:0]);
    empty = (cnt == 3'd0);
    grant = 1'b0;
    win   = 1'b0;
    if (lock_valid) begin
      grant = 1'b1;
      win   = lock_id;
    end else if (!full) begin
      if (inst_req && starve_cnt == STARVE_LIMIT[3:0]) begin
        grant = 1'b1;
        win   = 1'b0;
      end else if (data_req) begin
        grant = 1'b1;
        win   = 1'b1;
      end else if (inst_req) begin
        grant = 1'b1;
        win   = 1'b0;
      end
    end
    if (reset) grant = 1'b0;
    accept = grant && mem_addr_ok;
    pop    = mem_data_ok && !empty && !reset;
    head   = tags[rptr];
  end

  assign mem_req      = grant;
  assign mem_wr       = win ? data_wr    : inst_wr;
  assign mem_size     = win ? data_size  : inst_size;
  assign mem_wstrb    = win ? data_wstrb : inst_wstrb;
  assign mem_addr     = win ? data_addr  : inst_addr;
  assign mem_wdata    = win ? data_wdata : inst_wdata;
  assign inst_addr_ok = accept && !win;
  assign data_addr_ok = accept && win;
  assign inst_data_ok = pop && !head;
  assign data_data_ok = pop && head;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign outs_cnt     = cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= 3'd0;
      wptr         <= 3'd0;
      rptr         <= 3'd0;
      tags         <= 8'd0;
      lock_valid   <= 1'b0;
      lock_id      <= 1'b0;
      starve_cnt   <= 4'd0;
      err_spurious <= 1'b0;
    end else begin
      if (accept) begin
        tags[wptr] <= win;
        wptr       <= ptr_inc(wptr);
      end
      if (pop) rptr <= ptr_inc(rptr);
      if (accept && !pop)      cnt <= cnt + 3'd1;
      else if (pop && !accept) cnt <= cnt - 3'd1;

      if (grant && !mem_addr_ok) begin
        lock_valid <= 1'b1;
        lock_id    <= win;
      end else if (accept) begin
        lock_valid <= 1'b0;
      end

      // Counts data wins that happened while fetch was waiting.
      if (!inst_req)                 starve_cnt <= 4'd0;
      else if (accept && !win)       starve_cnt <= 4'd0;
      else if (accept && win && starve_cnt < STARVE_LIMIT[3:0])
        starve_cnt <= starve_cnt + 4'd1;

      if (mem_data_ok && empty) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter (MAX_OUTS=2, STARVE_LIMIT=4); inputs change 2ns after
// each rising edge and outputs are checked 1ns later.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [3:0]  inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  outs_cnt;
  logic        err_spurious;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.MAX_OUTS(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .outs_cnt(outs_cnt), .err_spurious(err_spurious)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  initial begin
    idle();
    // Reset holds every handshake output low even with all inputs active.
    reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    tick(); settle();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_inst_addr_ok", inst_addr_ok, 0);
    chk("rst_data_addr_ok", data_addr_ok, 0);
    chk("rst_data_data_ok", data_data_ok, 0);
    chk("rst_inst_data_ok", inst_data_ok, 0);
    idle();
    tick(); reset = 0; settle();
    chk("rst_outs", outs_cnt, 0);
    chk("rst_err", err_spurious, 0);

    // T1: single fetch, response two cycles after accept.
    tick(); inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1; settle();
    chk("t1_mem_req", mem_req, 1);
    chk("t1_mem_addr", mem_addr, 32'h1c000000);
    chk("t1_inst_addr_ok", inst_addr_ok, 1);
    chk("t1_data_addr_ok", data_addr_ok, 0);
    tick(); inst_req = 0; mem_addr_ok = 0; settle();
    chk("t1_outs_1", outs_cnt, 1);
    chk("t1_no_data_ok", inst_data_ok, 0);
    tick(); mem_data_ok = 1; mem_rdata = 32'h02800000; settle();
    chk("t1_inst_data_ok", inst_data_ok, 1);
    chk("t1_data_data_ok", data_data_ok, 0);
    chk("t1_inst_rdata", inst_rdata, 32'h02800000);
    tick(); mem_data_ok = 0; settle();
    chk("t1_outs_0", outs_cnt, 0);

    // T2: simultaneous requests, data first; responses return data then inst.
    tick();
    inst_req = 1; inst_addr = 32'h200;
    data_req = 1; data_addr = 32'h100; data_wr = 1; data_wstrb = 4'h3; data_wdata = 32'hdeadbeef;
    mem_addr_ok = 1; settle();
    chk("t2_data_addr_ok", data_addr_ok, 1);
    chk("t2_inst_addr_ok0", inst_addr_ok, 0);
    chk("t2_mem_addr_d", mem_addr, 32'h100);
    chk("t2_mem_wr", mem_wr, 1);
    chk("t2_mem_wstrb", mem_wstrb, 4'h3);
    chk("t2_mem_wdata", mem_wdata, 32'hdeadbeef);
    tick(); data_req = 0; data_wr = 0; settle();
    chk("t2_inst_addr_ok", inst_addr_ok, 1);
    chk("t2_mem_addr_i", mem_addr, 32'h200);
    chk("t2_mem_wr_i", mem_wr, 0);
    tick(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'haaaa0001; settle();
    chk("t2_outs_2", outs_cnt, 2);
    chk("t2_resp1_data", data_data_ok, 1);
    chk("t2_resp1_inst", inst_data_ok, 0);
    chk("t2_data_rdata", data_rdata, 32'haaaa0001);
    tick(); mem_rdata = 32'hbbbb0002; settle();
    chk("t2_resp2_inst", inst_data_ok, 1);
    chk("t2_resp2_data", data_data_ok, 0);
    tick(); mem_data_ok = 0; settle();
    chk("t2_outs_0", outs_cnt, 0);

    // T3: fetch locked while memory stalls; data waits until the fetch is taken.
    tick(); inst_req = 1; inst_addr = 32'h300; mem_addr_ok = 0; settle();
    chk("t3_c0_mem_addr", mem_addr, 32'h300);
    chk("t3_c0_mem_req", mem_req, 1);
    tick(); data_req = 1; data_addr = 32'h400; settle();
    chk("t3_c1_mem_addr", mem_addr, 32'h300);
    chk("t3_c1_data_addr_ok", data_addr_ok, 0);
    tick(); settle();
    chk("t3_c2_mem_addr", mem_addr, 32'h300);
    tick(); mem_addr_ok = 1; settle();
    chk("t3_c3_mem_addr", mem_addr, 32'h300);
    chk("t3_c3_inst_addr_ok", inst_addr_ok, 1);
    chk("t3_c3_data_addr_ok", data_addr_ok, 0);
    tick(); inst_req = 0; settle();
    chk("t3_c4_mem_addr", mem_addr, 32'h400);
    chk("t3_c4_data_addr_ok", data_addr_ok, 1);
    tick(); data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; settle();
    chk("t3_outs_2", outs_cnt, 2);
    chk("t3_resp1_inst", inst_data_ok, 1);
    tick(); settle();
    chk("t3_resp2_data", data_data_ok, 1);
    tick(); mem_data_ok = 0; settle();
    chk("t3_outs_0", outs_cnt, 0);

    // T4: FIFO full blocks requests, no same-cycle bypass on a response.
    tick(); inst_req = 1; inst_addr = 32'h500; mem_addr_ok = 1; settle();
    chk("t4_acc1", inst_addr_ok, 1);
    tick(); inst_req = 0; data_req = 1; data_addr = 32'h600; settle();
    chk("t4_acc2", data_addr_ok, 1);
    tick(); data_addr = 32'h700; settle();
    chk("t4_full_mem_req", mem_req, 0);
    chk("t4_full_addr_ok", data_addr_ok, 0);
    chk("t4_outs_2", outs_cnt, 2);
    tick(); mem_data_ok = 1; settle();
    chk("t4_pop_mem_req", mem_req, 0);
    chk("t4_pop_inst_ok", inst_data_ok, 1);
    tick(); mem_data_ok = 0; settle();
    chk("t4_outs_1", outs_cnt, 1);
    chk("t4_issue", data_addr_ok, 1);
    chk("t4_issue_addr", mem_addr, 32'h700);
    tick(); data_req = 0; mem_addr_ok = 0; settle();
    chk("t4_outs_peak", outs_cnt, 2);
    mem_data_ok = 1;
    tick(); settle();
    chk("t4_drain", data_data_ok, 1);
    tick(); mem_data_ok = 0; settle();
    chk("t4_outs_0", outs_cnt, 0);

    // T5: four data grants, then fetch forced, then data again.
    tick(); inst_req = 1; data_req = 1; inst_addr = 32'h800; data_addr = 32'h900; mem_addr_ok = 1; settle();
    chk("t5_g0", data_addr_ok, 1);
    for (int k = 1; k < 4; k++) begin
      tick(); mem_data_ok = 1; settle();
      chk($sformatf("t5_g%0d", k), data_addr_ok, 1);
      chk($sformatf("t5_i%0d", k), inst_addr_ok, 0);
    end
    tick(); settle();
    chk("t5_forced_inst", inst_addr_ok, 1);
    chk("t5_forced_data", data_addr_ok, 0);
    chk("t5_outs_steady", outs_cnt, 1);
    tick(); settle();
    chk("t5_after_data", data_addr_ok, 1);
    tick(); inst_req = 0; data_req = 0; mem_addr_ok = 0; settle();
    chk("t5_last_pop", data_data_ok, 1);
    tick(); mem_data_ok = 0; settle();
    chk("t5_outs_0", outs_cnt, 0);

    // T6: spurious response, then reset with two requests outstanding.
    tick(); mem_data_ok = 1; settle();
    chk("t6_no_inst_ok", inst_data_ok, 0);
    chk("t6_no_data_ok", data_data_ok, 0);
    chk("t6_err_before", err_spurious, 0);
    tick(); mem_data_ok = 0; settle();
    chk("t6_err_set", err_spurious, 1);
    tick(); inst_req = 1; mem_addr_ok = 1; settle();
    chk("t6_err_held", err_spurious, 1);
    tick(); inst_req = 0; data_req = 1; settle();
    tick(); data_req = 0; mem_addr_ok = 0; settle();
    chk("t6_outs_2", outs_cnt, 2);
    reset = 1;
    tick(); reset = 0; settle();
    chk("t6_rst_outs", outs_cnt, 0);
    chk("t6_rst_err", err_spurious, 0);
    mem_data_ok = 1;
    tick(); settle();
    chk("t6_rst_fifo_empty", inst_data_ok | data_data_ok, 0);
    mem_data_ok = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
